hood_status_indicator: RTL and testbench

Parametrised status/indicator block for the range-hood controller: takes the main FSM state code, filters it for stability, and produces registered status flags, a one-hot fan-level vector and blinking LED drives. It sits between the control FSM and the board LEDs/downstream timers. It generalises the fixed three-level decode to NUM_LEVELS fan levels, and adds input de-glitching, change pulses, illegal-code trapping and blink patterns.

---
 rtl/hood_state_pkg.sv | 38 +++
 rtl/hood_status_indicator_blink.sv | 45 ++++
 rtl/hood_status_indicator.sv | 243 ++++++++++++++++++++++++
 tb/tb_hood_status_indicator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hood_state_pkg.sv
// Shared state-code definitions for the range-hood controller.
// The control FSM and the status indicator both import this package so
// that the numeric state encoding lives in exactly one place.
package hood_state_pkg;

    // Fixed state codes; fan level i (0-based) is encoded as LEVEL_BASE + i.
    localparam int unsigned ST_OFF             = 0;
    localparam int unsigned ST_STANDBY         = 1;
    localparam int unsigned ST_MODE_SELECT     = 2;
    localparam int unsigned ST_SELF_CLEAN      = 3;
    localparam int unsigned ST_WAIT_TO_STANDBY = 4;
    localparam int unsigned LEVEL_BASE         = 5;

    // Coarse classification of an accepted state code, used to drive the
    // flag and LED decode without repeating range compares everywhere.
    typedef enum logic [2:0] {
        MODE_OFF        = 3'd0,
        MODE_STANDBY    = 3'd1,
        MODE_SELECT     = 3'd2,
        MODE_SELF_CLEAN = 3'd3,
        MODE_WAIT       = 3'd4,
        MODE_LEVEL      = 3'd5,
        MODE_ILLEGAL    = 3'd6
    } hood_mode_e;

    // True when code is one of the n fan-level codes. Callers zero-extend
    // the state code to 32 bits, so the compare stays unsigned even when
    // LEVEL_BASE + n does not fit in the native state width.
    function automatic logic is_level(input logic [31:0] code, input int unsigned n);
        return (code >= LEVEL_BASE) && (code < (LEVEL_BASE + n));
    endfunction

    // True when code lies beyond the highest fan-level code.
    function automatic logic is_illegal(input logic [31:0] code, input int unsigned n);
        return code >= (LEVEL_BASE + n);
    endfunction

endpackage

// File: rtl/hood_status_indicator_blink.sv
// Square-wave blink generator. The phase toggles every HALF clock cycles.
// A restart clears the counter and forces the phase ON, so any LED pattern
// that begins on a restart starts lit and shows a full first half period.
module blink_gen #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);

    localparam int unsigned W    = $clog2(HALF);
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    // Next-state: restart has priority, otherwise count and toggle on wrap.
    always_comb begin
        cnt_d   = cnt_q + W'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Counter and phase registers; reset leaves the phase ON.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/hood_status_indicator.sv
// Status/indicator block for the range-hood controller. The raw FSM state
// code is de-glitched by a stability filter; the accepted code is decoded
// into registered status flags, a one-hot fan-level vector and LED drives
// that blink slow/fast depending on the mode. An accepted code outside the
// legal range raises a sticky fault that only OFF (or reset) clears.
module hood_status_indicator
    import hood_state_pkg::*;
#(
    parameter int unsigned NUM_LEVELS    = 3,
    parameter int unsigned STATE_W       = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned SLOW_HALF     = 50_000_000,
    parameter int unsigned FAST_HALF     = 12_500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STATE_W-1:0]    state,
    output logic                  is_power_on,
    output logic                  is_working,
    output logic                  is_self_clean,
    output logic                  is_standby,
    output logic                  is_countdown_active,
    output logic [NUM_LEVELS-1:0] level_onehot,
    output logic                  state_changed,
    output logic                  illegal_state,
    output logic                  led_power,
    output logic [NUM_LEVELS-1:0] led_level,
    output logic                  led_clean
);

    // Hold counter needs at least one bit even when a single sample suffices.
    localparam int unsigned      CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [STATE_W-1:0] OFF_W     = STATE_W'(ST_OFF);
    localparam logic [STATE_W-1:0] STANDBY_W = STATE_W'(ST_STANDBY);
    localparam logic [STATE_W-1:0] SELECT_W  = STATE_W'(ST_MODE_SELECT);
    localparam logic [STATE_W-1:0] CLEAN_W   = STATE_W'(ST_SELF_CLEAN);
    localparam logic [STATE_W-1:0] WAIT_W    = STATE_W'(ST_WAIT_TO_STANDBY);
    localparam logic [STATE_W-1:0] LBASE_W   = STATE_W'(LEVEL_BASE);
    localparam logic [STATE_W-1:0] TOP_IDX   = STATE_W'(NUM_LEVELS - 1);

    // Stability filter registers.
    logic [STATE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] acc_q, acc_d;
    logic               accept;
    logic               chg_q;

    // Decode of the accepted code.
    hood_mode_e          mode;
    logic [31:0]         acc_ext;
    logic [STATE_W-1:0]  lvl_idx;
    logic [NUM_LEVELS-1:0] lvl_onehot;
    logic                is_top;

    // Blink phases.
    logic slow_ph, fast_ph;

    // Registered outputs.
    logic                  pwr_q, pwr_d;
    logic                  work_q, work_d;
    logic                  clean_q, clean_d;
    logic                  stby_q, stby_d;
    logic                  cdown_q, cdown_d;
    logic [NUM_LEVELS-1:0] level_q, level_d;
    logic                  changed_q;
    logic                  illegal_q, illegal_d;
    logic                  led_pwr_q, led_pwr_d;
    logic [NUM_LEVELS-1:0] led_lvl_q, led_lvl_d;
    logic                  led_cln_q, led_cln_d;

    // Filter next-state: a new code restarts the hold count; once it has been
    // held long enough and differs from the accepted code, it is accepted.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        accept = 1'b0;
        if (state != cand_q) begin
            cand_d = state;
            cnt_d  = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != acc_q) begin
            acc_d  = cand_q;
            accept = 1'b1;
        end
    end

    // Filter registers; chg_q marks the cycle in which acc_q just changed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= OFF_W;
            cnt_q  <= '0;
            acc_q  <= OFF_W;
            chg_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            chg_q  <= accept;
        end
    end

    // Both blink generators restart on every acceptance so new patterns start lit.
    blink_gen #(.HALF(SLOW_HALF)) u_slow_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .phase   (slow_ph)
    );

    blink_gen #(.HALF(FAST_HALF)) u_fast_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .phase   (fast_ph)
    );

    // Classify the accepted code and derive the fan-level index.
    always_comb begin
        acc_ext = 32'(acc_q);
        lvl_idx = acc_q - LBASE_W;
        if (acc_q == OFF_W)                        mode = MODE_OFF;
        else if (acc_q == STANDBY_W)               mode = MODE_STANDBY;
        else if (acc_q == SELECT_W)                mode = MODE_SELECT;
        else if (acc_q == CLEAN_W)                 mode = MODE_SELF_CLEAN;
        else if (acc_q == WAIT_W)                  mode = MODE_WAIT;
        else if (is_level(acc_ext, NUM_LEVELS))    mode = MODE_LEVEL;
        else if (is_illegal(acc_ext, NUM_LEVELS))  mode = MODE_ILLEGAL;
        else                                       mode = MODE_ILLEGAL;
    end

    // One-hot fan level and top-level detect for the accepted code.
    always_comb begin
        lvl_onehot = '0;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            lvl_onehot[i] = (mode == MODE_LEVEL) && (lvl_idx == STATE_W'(i));
        end
        is_top = (mode == MODE_LEVEL) && (lvl_idx == TOP_IDX);
    end

    // Flag and LED decode; the fault flag is sticky until OFF is accepted.
    always_comb begin
        pwr_d     = 1'b0;
        work_d    = 1'b0;
        clean_d   = 1'b0;
        stby_d    = 1'b0;
        cdown_d   = 1'b0;
        level_d   = '0;
        led_pwr_d = 1'b0;
        led_lvl_d = '0;
        led_cln_d = 1'b0;
        illegal_d = illegal_q;
        case (mode)
            MODE_OFF: begin
                illegal_d = 1'b0;
            end
            MODE_STANDBY: begin
                pwr_d     = 1'b1;
                stby_d    = 1'b1;
                led_pwr_d = slow_ph;
            end
            MODE_SELECT: begin
                pwr_d     = 1'b1;
                led_pwr_d = 1'b1;
                led_lvl_d = {NUM_LEVELS{slow_ph}};
            end
            MODE_SELF_CLEAN: begin
                pwr_d     = 1'b1;
                clean_d   = 1'b1;
                cdown_d   = 1'b1;
                led_pwr_d = 1'b1;
                led_cln_d = slow_ph;
            end
            MODE_WAIT: begin
                pwr_d     = 1'b1;
                work_d    = 1'b1;
                cdown_d   = 1'b1;
                led_pwr_d = 1'b1;
                led_lvl_d[NUM_LEVELS-1] = fast_ph;
            end
            MODE_LEVEL: begin
                pwr_d     = 1'b1;
                work_d    = 1'b1;
                cdown_d   = is_top;
                level_d   = lvl_onehot;
                led_pwr_d = 1'b1;
                led_lvl_d = lvl_onehot;
            end
            default: begin
                illegal_d = 1'b1;
                pwr_d     = 1'b1;
                led_pwr_d = fast_ph;
                led_lvl_d = {NUM_LEVELS{fast_ph}};
                led_cln_d = fast_ph;
            end
        endcase
    end

    // Output registers: all outputs follow acc_q by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_q     <= 1'b0;
            work_q    <= 1'b0;
            clean_q   <= 1'b0;
            stby_q    <= 1'b0;
            cdown_q   <= 1'b0;
            level_q   <= '0;
            changed_q <= 1'b0;
            illegal_q <= 1'b0;
            led_pwr_q <= 1'b0;
            led_lvl_q <= '0;
            led_cln_q <= 1'b0;
        end else begin
            pwr_q     <= pwr_d;
            work_q    <= work_d;
            clean_q   <= clean_d;
            stby_q    <= stby_d;
            cdown_q   <= cdown_d;
            level_q   <= level_d;
            changed_q <= chg_q;
            illegal_q <= illegal_d;
            led_pwr_q <= led_pwr_d;
            led_lvl_q <= led_lvl_d;
            led_cln_q <= led_cln_d;
        end
    end

    assign is_power_on         = pwr_q;
    assign is_working          = work_q;
    assign is_self_clean       = clean_q;
    assign is_standby          = stby_q;
    assign is_countdown_active = cdown_q;
    assign level_onehot        = level_q;
    assign state_changed       = changed_q;
    assign illegal_state       = illegal_q;
    assign led_power           = led_pwr_q;
    assign led_level           = led_lvl_q;
    assign led_clean           = led_cln_q;

endmodule

// File: tb/tb_hood_status_indicator.sv
// Bench for hood_status_indicator with 3 fan levels, 2-cycle filter,
// slow half period 8 and fast half period 2. A behavioural model predicts
// the full output vector after every clock edge; predictions go into a
// queue and are compared against the DUT half a cycle later.
module tb_hood_status_indicator;

    localparam int unsigned NL = 3;
    localparam int unsigned SW = 4;
    localparam int unsigned SC = 2;
    localparam int unsigned SH = 8;
    localparam int unsigned FH = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic [SW-1:0] state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          is_power_on, is_working, is_self_clean, is_standby;
    logic          is_countdown_active, state_changed, illegal_state;
    logic [NL-1:0] level_onehot, led_level;
    logic          led_power, led_clean;

    hood_status_indicator #(
        .NUM_LEVELS    (NL),
        .STATE_W       (SW),
        .STABLE_CYCLES (SC),
        .SLOW_HALF     (SH),
        .FAST_HALF     (FH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .state               (state),
        .is_power_on         (is_power_on),
        .is_working          (is_working),
        .is_self_clean       (is_self_clean),
        .is_standby          (is_standby),
        .is_countdown_active (is_countdown_active),
        .level_onehot        (level_onehot),
        .state_changed       (state_changed),
        .illegal_state       (illegal_state),
        .led_power           (led_power),
        .led_level           (led_level),
        .led_clean           (led_clean)
    );

    // Packed view: {pwr,work,clean,stby,cdown,chg,ill,lvl[2:0],ledp,ledl[2:0],ledc}
    logic [14:0] obs;
    assign obs = {is_power_on, is_working, is_self_clean, is_standby,
                  is_countdown_active, state_changed, illegal_state,
                  level_onehot, led_power, led_level, led_clean};

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SW-1:0] m_acc, m_run_val;
    int            m_run_len, m_ns, m_nf;
    logic          m_chg, m_ill;

    function automatic logic [14:0] spec_outputs(input logic [SW-1:0] code, input logic slow,
                                                 input logic fast, input logic chg, input logic ill);
        logic pw, wk, sc, sb, cd, lp, lc;
        logic [2:0] lv, ll;
        pw = 0; wk = 0; sc = 0; sb = 0; cd = 0; lp = 0; lc = 0; lv = 3'b000; ll = 3'b000;
        case (code)
            4'd0: ;
            4'd1: begin pw = 1; sb = 1; lp = slow; end
            4'd2: begin pw = 1; lp = 1; ll = {slow, slow, slow}; end
            4'd3: begin pw = 1; sc = 1; cd = 1; lp = 1; lc = slow; end
            4'd4: begin pw = 1; wk = 1; cd = 1; lp = 1; ll = {fast, 2'b00}; end
            4'd5: begin pw = 1; wk = 1; lv = 3'b001; lp = 1; ll = 3'b001; end
            4'd6: begin pw = 1; wk = 1; lv = 3'b010; lp = 1; ll = 3'b010; end
            4'd7: begin pw = 1; wk = 1; cd = 1; lv = 3'b100; lp = 1; ll = 3'b100; end
            default: begin pw = 1; lp = fast; ll = {fast, fast, fast}; lc = fast; end
        endcase
        return {pw, wk, sc, sb, cd, chg, ill, lv, lp, ll, lc};
    endfunction

    task automatic model_reset();
        m_acc     = '0;
        m_run_val = '0;
        m_run_len = 1;
        m_ns      = 0;
        m_nf      = 0;
        m_chg     = 1'b0;
        m_ill     = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge that sampled input s.
    task automatic model_edge(input logic [SW-1:0] s);
        logic slow, fast;
        slow = ((m_ns / int'(SH)) % 2) == 0;
        fast = ((m_nf / int'(FH)) % 2) == 0;
        if (m_acc >= 4'd8)      m_ill = 1'b1;
        else if (m_acc == 4'd0) m_ill = 1'b0;
        exp_q.push_back(spec_outputs(m_acc, slow, fast, m_chg, m_ill));
        if (s == m_run_val) begin
            if (m_run_len < 100) m_run_len++;
        end else begin
            m_run_val = s;
            m_run_len = 1;
        end
        if (m_run_len >= int'(SC) + 1 && m_run_val != m_acc) begin
            m_acc = m_run_val;
            m_ns  = 0;
            m_nf  = 0;
            m_chg = 1'b1;
        end else begin
            m_ns++;
            m_nf++;
            m_chg = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: drive, clock, predict, compare.
    task automatic step(input logic [SW-1:0] code);
        logic [14:0] e;
        state = code;
        @(posedge clk);
        model_edge(code);
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("cyc%0d st%0d outs", cyc, code), 32'(obs), 32'(e));
        end else begin
            check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic hold(input logic [SW-1:0] code, input int n);
        for (int i = 0; i < n; i++) step(code);
    endtask

    // Assert reset in the middle of a cycle and check the asynchronous clear.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_eq({tag, "_async"}, 32'(obs), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_hold"}, 32'(obs), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        state = '0;
        #2 rst_n = 1'b0;
        #1 check_eq("reset_outs", 32'(obs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_hold", 32'(obs), 32'd0);
        model_reset();
        rst_n = 1'b1;

        hold(4'd0, 3);
        // Standby: slow blink on the power LED, 8 on then 8 off.
        hold(4'd1, 24);
        // Top level: steady top LED, countdown active.
        hold(4'd7, 10);
        // Single-cycle and two-cycle glitches inside a long standby run.
        hold(4'd1, 10);
        hold(4'd5, 1);
        hold(4'd1, 8);
        hold(4'd5, 2);
        hold(4'd1, 8);
        // Wait-to-standby: fast blink on the top level LED.
        hold(4'd4, 12);
        // Illegal code, then legal non-OFF keeps the fault, OFF clears it.
        hold(4'd12, 10);
        hold(4'd1, 8);
        hold(4'd0, 8);
        // Mode select and lower fan levels.
        hold(4'd2, 20);
        hold(4'd6, 6);
        // Changes accepted as soon as the filter allows.
        hold(4'd5, 3);
        hold(4'd6, 3);
        hold(4'd7, 3);
        hold(4'd5, 6);
        // Self clean, reset in the middle, then reacceptance.
        hold(4'd3, 12);
        async_reset("mid_clean");
        hold(4'd3, 14);
        // Random segments including illegal codes and short glitches.
        for (int k = 0; k < 30; k++) begin
            hold(4'($urandom_range(0, 15)), int'($urandom_range(1, 6)));
        end
        // Reset while the filter is mid-count.
        hold(4'd2, 1);
        async_reset("mid_filter");
        hold(4'd2, 6);
        hold(4'd0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
